// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial two's complement adder/subtractor.
// One full adder is reused over N clock cycles, LSB first. Subtraction is
// done as A + ~B + 1 (borrow-in folded into the initial carry), so cout
// reads 1 for "no borrow" in subtract mode. s/cout/ovf are registered and
// change only when a complete result is ready.
module serial_add_sub #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    input  logic         sub,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  res_q;
    logic [CW-1:0] count;
    logic          carry;

    logic          accept;
    logic          last;
    logic          sum_bit;
    logic          carry_nxt;

    // A new operation may start whenever no shift is in progress.
    assign accept    = start && (state != SHIFT);
    assign last      = (count == CW'(N - 1));
    assign sum_bit   = a_q[count] ^ b_q[count] ^ carry;
    assign carry_nxt = (a_q[count] & b_q[count]) | (carry & (a_q[count] ^ b_q[count]));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Operand capture, serial add step and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            count <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B ^ {N{sub}};
            carry <= cin ^ sub;
            count <= '0;
        end else if (state == SHIFT) begin
            // Sum bits enter at the MSB and move down, so after N steps
            // bit 0 of the result sits at res_q[0].
            res_q <= {sum_bit, res_q[N-1:1]};
            carry <= carry_nxt;
            count <= count + 1'b1;
            if (last) begin
                s    <= {sum_bit, res_q[N-1:1]};
                cout <= carry_nxt;
                ovf  <= carry ^ carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: a cycle-level reference model
// computes results with plain integer arithmetic and a busy countdown; a
// compare process checks every output on every falling edge.
module tb_serial_add_sub;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    int checks;
    int failures;
    int done_cnt;

    serial_add_sub #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_left;
    logic         m_done;
    logic [N-1:0] m_s;
    logic         m_cout;
    logic         m_ovf;
    logic [N-1:0] p_s;
    logic         p_cout;
    logic         p_ovf;

    task automatic calc(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic sb,
                        output logic [N-1:0] rs, output logic rc, output logic ro);
        int ua, ub, sa, sbv, total, truev;
        ua  = int'(a);
        ub  = int'(b);
        sa  = a[N-1] ? ua - (2 ** N) : ua;
        sbv = b[N-1] ? ub - (2 ** N) : ub;
        if (sb) begin
            total = ua + ((2 ** N - 1) - ub) + (ci ? 0 : 1);
            truev = sa - sbv - (ci ? 1 : 0);
        end else begin
            total = ua + ub + (ci ? 1 : 0);
            truev = sa + sbv + (ci ? 1 : 0);
        end
        rs = N'(total % (2 ** N));
        rc = (total >= (2 ** N));
        ro = (truev > (2 ** (N - 1) - 1)) || (truev < -(2 ** (N - 1)));
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_s    = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_s    = p_s;
                    m_cout = p_cout;
                    m_ovf  = p_ovf;
                end
            end else if (start) begin
                calc(A, B, cin, sub, p_s, p_cout, p_ovf);
                m_left = N;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("s",    32'(s),    32'(m_s));
        chk("cout", 32'(cout), 32'(m_cout));
        chk("ovf",  32'(ovf),  32'(m_ovf));
        if (done) done_cnt++;
    end

    // ---------------- directed helpers ----------------
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic ci, input logic sb,
                      input logic [N-1:0] es, input logic ec, input logic eo,
                      input string nm);
        int n;
        @(negedge clk); #1;
        A = a; B = b; cin = ci; sub = sb; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        // scramble inputs after acceptance; result must not change
        A = N'($urandom); B = N'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({nm, "_timeout"}, 32'(done), 32'(1));
        end else begin
            chk({nm, "_s"},    32'(s),    32'(es));
            chk({nm, "_cout"}, 32'(cout), 32'(ec));
            chk({nm, "_ovf"},  32'(ovf),  32'(eo));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        checks = 0; failures = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_s",    32'(s),    32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_ovf",  32'(ovf),  32'(0));
        #1 rst_n = 1'b1;

        // literal vectors
        op(4'd1,  4'd3,  1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, "v_1p3");
        op(4'hD,  4'd5,  1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, "v_m3p5");
        op(4'd2,  4'hB,  1'b0, 1'b0, 4'b1101, 1'b0, 1'b0, "v_2pm5");
        op(4'd5,  4'hD,  1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, "v_5mm3");
        op(4'd7,  4'd1,  1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, "v_7p1");
        op(4'd3,  4'd5,  1'b1, 1'b1, 4'b1101, 1'b0, 1'b0, "v_3m5b");
        op(4'hF,  4'd1,  1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, "v_m1p1c");

        // start re-pulsed while busy must be ignored
        @(negedge clk); #1;
        A = 4'd3; B = 4'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk); #1;
        A = 4'd7; B = 4'd7; sub = 1'b1;
        dc = 0;
        for (int i = 0; i < N + 3; i++) begin
            if (i == 3) start = 1'b0;
            @(negedge clk);
            if (done) begin
                dc++;
                chk("ign_s", 32'(s), 32'(4'b0101));
            end
            #1;
            start = (i < 2);
        end
        start = 1'b0;
        chk("ign_done_count", 32'(dc), 32'(1));

        // start held high: back-to-back operations
        @(negedge clk); #1;
        A = 4'd1; B = 4'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
        dc = 0;
        for (int j = 0; j < 3 * N + 3; j++) begin
            @(negedge clk);
            if (done) begin
                dc++;
                chk("b2b_s", 32'(s), 32'(4'b0010));
            end
            chk("b2b_busy", 32'(busy), 32'(!done));
        end
        #1 start = 1'b0;
        chk("b2b_done_count", 32'(dc), 32'(3));

        // reset during SHIFT aborts
        @(negedge clk); #1;
        A = 4'd5; B = 4'd6; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_s",    32'(s),    32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
        chk("abort_ovf",  32'(ovf),  32'(0));
        @(negedge clk); #1 rst_n = 1'b1;
        dc = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("abort_no_done", 32'(dc), 32'(0));
        op(4'd2, 4'd2, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, "v_after_rst");

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            A = N'($urandom); B = N'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        #1 start = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter: N, default 4, operand and result width in bits (N >= 2).
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-005 Port: A  input  N  first operand, two's complement; captured when start is accepted.
REQ-006 Port: B  input  N  second operand, two's complement; captured when start is accepted.
REQ-007 Port: cin  input  1  carry-in in add mode, borrow-in in subtract mode; captured when start is accepted.
REQ-008 Port: sub  input  1  mode select: 0 = A+B+cin, 1 = A-B-cin; captured when start is accepted.
REQ-009 Port: busy  output  1  high while the SHIFT state is active.
REQ-010 Port: done  output  1  one-cycle pulse marking that the result outputs are valid and new.
REQ-011 Port: s  output  N  result, registered.
REQ-012 Port: cout  output  1  final carry out; in subtract mode 1 = no borrow.
REQ-013 Port: ovf  output  1  signed overflow flag, registered.

Function
REQ-014 The block shall compute with one full adder reused over N cycles, processing operand bits LSB first.
REQ-015 The state machine shall use three states: IDLE, SHIFT and DONE.
REQ-016 start shall be accepted only when busy=0 (IDLE or DONE); acceptance shall cause the transition to SHIFT with the bit counter set to 0.
REQ-017 On acceptance the block shall latch A, latch B XOR {N{sub}}, and set the internal carry to cin XOR sub.
REQ-018 Each SHIFT cycle shall add latched bit[count] of A and B with the carry, shift the sum bit into an internal result register, update the carry, and increment count.
REQ-019 After the SHIFT cycle with count = N-1, the FSM shall go to DONE.
REQ-020 On entry to DONE, s, cout and ovf shall be updated, with ovf = (carry into MSB) XOR (carry out of MSB).
REQ-021 Latency: start accepted at edge k -> busy high from edge k to edge k+N -> done high for exactly the cycle after edge k+N.
REQ-022 DONE shall return to IDLE after one cycle unless a new start is accepted in DONE, which goes directly to SHIFT (back-to-back operation, done still drops).
REQ-023 start asserted while busy=1 shall be ignored: no effect on the operation in progress or on the latched operands.
REQ-024 s, cout and ovf shall hold their values until the next DONE entry; partial sums shall never appear on s.
REQ-025 Changes on A, B, cin or sub after acceptance shall not affect the result in progress.
REQ-026 Arithmetic shall wrap modulo 2^N; overflow is reported only through ovf.

Reset
REQ-027 rst_n=0 shall immediately force IDLE, count=0, internal carry=0, busy=0, done=0, s=0, cout=0 and ovf=0, regardless of clk.
REQ-028 A reset during SHIFT shall abort the operation; no done pulse shall follow and the old s value shall not be preserved.
REQ-029 After rst_n deasserts, the first rising edge with start=1 shall be accepted normally.

Verification
REQ-030 N=4, A=1, B=3, cin=0, sub=0 -> after 4 busy cycles, done pulse with s=4'b0100, cout=0, ovf=0.
REQ-031 A=-3 (1101), B=5, sub=0 -> s=4'b0010, cout=1, ovf=0; then A=2, B=-5 (1011), sub=0 -> s=4'b1101, cout=0, ovf=0.
REQ-032 A=5, B=-3, sub=1, cin=0 -> s=4'b1000, cout=0, ovf=1; and A=7, B=1, sub=0 -> s=4'b1000, ovf=1.
REQ-033 start pulsed again at cycles 1-3 of a busy operation, with different A and B -> result matches the first operands and exactly one done pulse occurs.
REQ-034 start held high continuously with A=1, B=1 -> a done pulse every N+1 cycles, s=4'b0010 each time, busy low only during the DONE cycles.
REQ-035 rst_n pulsed low during cycle 2 of SHIFT -> all outputs 0 immediately, no done pulse; the next start (A=2, B=2) yields s=4'b0100.
